// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length tap masks for widths 3..16 and lock-up status type.
package lfsr_pkg;

  // Bit i set => state[i] feeds the XOR; shift is toward the MSB.
  localparam logic [2:0]  TAPS3  = 3'b110;
  localparam logic [3:0]  TAPS4  = 4'b1100;
  localparam logic [4:0]  TAPS5  = 5'b10100;
  localparam logic [5:0]  TAPS6  = 6'b110000;
  localparam logic [6:0]  TAPS7  = 7'b1100000;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [8:0]  TAPS9  = 9'h110;
  localparam logic [9:0]  TAPS10 = 10'h240;
  localparam logic [10:0] TAPS11 = 11'h500;
  localparam logic [11:0] TAPS12 = 12'h829;
  localparam logic [12:0] TAPS13 = 13'h100D;
  localparam logic [13:0] TAPS14 = 14'h2015;
  localparam logic [14:0] TAPS15 = 15'h6000;
  localparam logic [15:0] TAPS16 = 16'hD008;

  typedef enum logic {
    LOCK_OK     = 1'b0,
    LOCK_REJECT = 1'b1
  } lock_status_e;

  function automatic logic [15:0] max_taps(input int unsigned width);
    case (width)
      3:       return 16'(TAPS3);
      4:       return 16'(TAPS4);
      5:       return 16'(TAPS5);
      6:       return 16'(TAPS6);
      7:       return 16'(TAPS7);
      8:       return 16'(TAPS8);
      9:       return 16'(TAPS9);
      10:      return 16'(TAPS10);
      11:      return 16'(TAPS11);
      12:      return 16'(TAPS12);
      13:      return 16'(TAPS13);
      14:      return 16'(TAPS14);
      15:      return 16'(TAPS15);
      16:      return TAPS16;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Tracks the start state, counts steps and reports the measured period and wrap pulses.
module lfsr_period_mon import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] state_next_i,
  input  logic             step_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] period_o,
  output logic             period_vld_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = vld_q;
    wrap_d   = 1'b0;
    if (load_i) begin
      start_d = state_next_i;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else if (step_i) begin
      if (state_next_i == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + 1'b1;
        vld_d    = 1'b1;
        cnt_d    = '0;
      end else if (cnt_q != '1) begin
        // Saturate so a start state that is never revisited cannot fake a wrap.
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period_o     = period_q;
  assign period_vld_o = vld_q;
  assign wrap_o       = wrap_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, all-zero lock-up protection and period measurement.
module lfsr_gen import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = TAPS4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             lockup_err
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_gen: TAPS must include the MSB");
  end

  logic [WIDTH-1:0] state_q, state_d;
  lock_status_e     lock_q, lock_d;
  logic             fb;
  logic             step;

  always_comb begin
    fb      = ^(state_q & TAPS);
    step    = en && !load;
    state_d = state_q;
    lock_d  = LOCK_OK;
    if (load) begin
      if (seed_in != '0) begin
        state_d = seed_in;
      end else begin
        state_d = SEED;
        lock_d  = LOCK_REJECT;
      end
    end else if (en) begin
      state_d = {state_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
      lock_q  <= LOCK_OK;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  lfsr_period_mon #(
    .WIDTH(WIDTH),
    .SEED (SEED)
  ) u_mon (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .state_next_i(state_d),
    .step_i      (step),
    .load_i      (load),
    .period_o    (period),
    .period_vld_o(period_vld),
    .wrap_o      (wrap)
  );

  assign data_out   = state_q;
  assign bit_out    = state_q[WIDTH-1];
  assign lockup_err = (lock_q == LOCK_REJECT);

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit default instance and an 8-bit maximal-length instance.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en4 = 1'b0, load4 = 1'b0;
  logic [3:0] seed4 = '0;
  logic [3:0] d4, p4;
  logic       b4, w4, v4, l4;

  logic       en8 = 1'b0, load8 = 1'b0;
  logic [7:0] seed8 = '0;
  logic [7:0] d8, p8;
  logic       b8, w8, v8, l8;

  int total = 0;
  int bad   = 0;

  lfsr_gen dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .seed_in(seed4),
    .data_out(d4), .bit_out(b4), .wrap(w4), .period(p4),
    .period_vld(v4), .lockup_err(l4)
  );

  lfsr_gen #(
    .WIDTH(8),
    .TAPS (8'(max_taps(8))),
    .SEED (8'h01)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(load8), .seed_in(seed8),
    .data_out(d8), .bit_out(b8), .wrap(w8), .period(p8),
    .period_vld(v8), .lockup_err(l8)
  );

  // x^4+x^3+1 from seed 1
  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [7:0] seq8 [6] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  e;
    logic [29:0] pat;
    int          idx;
    int          wraps;
    int          reps;
    logic        seen [256];

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_data", 16'(d4), 16'h1);
    chk("rst_period", 16'(p4), 16'h0);
    chk("rst_vld", 16'(v4), 16'h0);
    chk("rst_wrap", 16'(w4), 16'h0);
    chk("rst_lock", 16'(l4), 16'h0);
    chk("rst_data8", 16'(d8), 16'h1);
    rst_n = 1'b1;

    // Test 1: full sequence from reset
    en4 = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      e = seq[i % 15];
      chk("t1_data", 16'(d4), 16'(e));
      chk("t1_bit", 16'(b4), 16'(e[3]));
      chk("t1_wrap", 16'(w4), 16'(i == 15));
      chk("t1_vld", 16'(v4), 16'(i == 15));
    end
    chk("t1_period", 16'(p4), 16'd15);

    // Hold
    en4 = 1'b0;
    tick();
    chk("hold_data", 16'(d4), 16'h1);
    chk("hold_wrap", 16'(w4), 16'h0);

    // Test 2: load A while en=1
    en4 = 1'b1; load4 = 1'b1; seed4 = 4'hA;
    tick();
    chk("t2_load_data", 16'(d4), 16'hA);
    chk("t2_load_vld", 16'(v4), 16'h0);
    chk("t2_load_period", 16'(p4), 16'd15);
    chk("t2_load_lock", 16'(l4), 16'h0);
    load4 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t2_data", 16'(d4), 16'(seq[(7 + i) % 15]));
      chk("t2_wrap", 16'(w4), 16'(i == 15));
    end
    chk("t2_period", 16'(p4), 16'd15);
    chk("t2_vld", 16'(v4), 16'h1);

    // Test 3: load zero is rejected
    load4 = 1'b1; seed4 = 4'h0;
    tick();
    chk("t3_data", 16'(d4), 16'h1);
    chk("t3_lock", 16'(l4), 16'h1);
    chk("t3_vld", 16'(v4), 16'h0);
    load4 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) chk("t3_lock_clr", 16'(l4), 16'h0);
      chk("t3_data_seq", 16'(d4), 16'(seq[i % 15]));
      chk("t3_wrap", 16'(w4), 16'(i == 15));
    end
    chk("t3_period", 16'(p4), 16'd15);

    // Test 4: irregular enable, 15 enabled cycles in 30
    pat = 30'b110010101100100111010001011010;
    idx = 0;
    for (int c = 29; c >= 0; c--) begin
      en4 = pat[c];
      tick();
      if (pat[c]) idx++;
      chk("t4_data", 16'(d4), 16'(seq[idx % 15]));
      chk("t4_wrap", 16'(w4), 16'(pat[c] && idx == 15));
    end
    chk("t4_steps", 16'(idx), 16'd15);
    chk("t4_period", 16'(p4), 16'd15);
    chk("t4_vld", 16'(v4), 16'h1);

    // Test 5: reset mid-sequence at D with load asserted
    en4 = 1'b1;
    repeat (6) tick();
    chk("t5_pre", 16'(d4), 16'hD);
    rst_n = 1'b0; load4 = 1'b1; seed4 = 4'h5;
    tick();
    chk("t5_data", 16'(d4), 16'h1);
    chk("t5_period", 16'(p4), 16'h0);
    chk("t5_vld", 16'(v4), 16'h0);
    chk("t5_wrap", 16'(w4), 16'h0);
    chk("t5_lock", 16'(l4), 16'h0);
    rst_n = 1'b1; load4 = 1'b0;
    tick();
    chk("t5_resume", 16'(d4), 16'h2);
    en4 = 1'b0;

    // Test 6: 8-bit maximal-length, 255 steps
    foreach (seen[k]) seen[k] = 1'b0;
    seen[1] = 1'b1;
    wraps = 0;
    reps  = 0;
    en8   = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i <= 6) chk("t6_data", 16'(d8), 16'(seq8[i - 1]));
      if (w8) wraps++;
      if (i < 255) begin
        if (seen[d8]) reps++;
        seen[d8] = 1'b1;
      end
      if (i == 254) chk("t6_vld_pre", 16'(v8), 16'h0);
    end
    chk("t6_wraps", 16'(wraps), 16'd1);
    chk("t6_wrap_last", 16'(w8), 16'h1);
    chk("t6_repeats", 16'(reps), 16'd0);
    chk("t6_data_end", 16'(d8), 16'h01);
    chk("t6_bit", 16'(b8), 16'h0);
    chk("t6_period", 16'(p8), 16'd255);
    chk("t6_vld", 16'(v8), 16'h1);
    chk("t6_lock", 16'(l8), 16'h0);
    en8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
